// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: RAW-hazard stall and taken-branch flush controller that sits beside the ID stage.
// Define PIPE_FORWARD_EN to enable EX/MEM operand forwarding, which leaves only load-use hazards stalling.
module pipe_hazard_ctrl #(
  parameter int NUM_STAGES = 3,
  parameter int REG_AW     = 5,
  parameter int ZERO_REG   = 31,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_AW-1:0]     id_rn,
  input  logic [REG_AW-1:0]     id_rm,
  input  logic                  id_uses_rn,
  input  logic                  id_uses_rm,
  input  logic [REG_AW-1:0]     id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  br_taken,
  output logic                  stall,
  output logic                  flush,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam logic [REG_AW-1:0] ZERO_ADDR = REG_AW'(ZERO_REG);

  if (NUM_STAGES < 2 || NUM_STAGES > 6) begin : g_bad_stages
    $error("pipe_hazard_ctrl: NUM_STAGES must be in 2..6");
  end

  logic [NUM_STAGES-1:0] ent_v;
  logic [NUM_STAGES-1:0] ent_rw;
  logic [NUM_STAGES-1:0] ent_mr;
  logic [REG_AW-1:0]     ent_rd [NUM_STAGES];

  logic [NUM_STAGES-1:0] match_a;
  logic [NUM_STAGES-1:0] match_b;
  logic                  rn_live;
  logic                  rm_live;
  logic                  hazard;
  logic                  issue;

  // The zero register is never a real dependency, whoever claims to write it.
  assign rn_live = id_uses_rn & (id_rn != ZERO_ADDR);
  assign rm_live = id_uses_rm & (id_rm != ZERO_ADDR);

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_match
    assign match_a[s] = ent_v[s] & ent_rw[s] & (ent_rd[s] == id_rn) & rn_live;
    assign match_b[s] = ent_v[s] & ent_rw[s] & (ent_rd[s] == id_rm) & rm_live;
  end

`ifdef PIPE_FORWARD_EN
  logic unused_match;
  assign unused_match = ^{match_a, match_b};

  // EX result is the youngest producer, so it wins over MEM.
  always_comb begin
    hazard = (match_a[0] | match_b[0]) & ent_mr[0];
    fwd_a  = 2'b00;
    fwd_b  = 2'b00;
    if (match_a[0])      fwd_a = 2'b01;
    else if (match_a[1]) fwd_a = 2'b10;
    if (match_b[0])      fwd_b = 2'b01;
    else if (match_b[1]) fwd_b = 2'b10;
  end
`else
  // The WB stage is excluded: the regfile writes before it is read in the same cycle.
  localparam logic [NUM_STAGES-1:0] HAZ_MASK = {1'b0, {(NUM_STAGES-1){1'b1}}};

  logic unused_load_info;
  assign unused_load_info = ^{id_mem_read, ent_mr};

  assign hazard = |((match_a | match_b) & HAZ_MASK);
  assign fwd_a  = 2'b00;
  assign fwd_b  = 2'b00;
`endif

  assign flush       = br_taken;
  assign stall       = hazard & id_valid & ~br_taken;
  assign issue       = id_valid & ~stall & ~flush;
  assign stage_valid = ent_v;

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_v     <= '0;
      stall_cnt <= '0;
    end else begin
      ent_v <= {ent_v[NUM_STAGES-2:0], issue};
      if (stall && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // Payload fields need no reset because a cleared valid bit masks them.
  always_ff @(posedge clk) begin
    ent_rw    <= {ent_rw[NUM_STAGES-2:0], id_reg_write};
    ent_mr    <= {ent_mr[NUM_STAGES-2:0], id_mem_read};
    ent_rd[0] <= id_rd;
    for (int s = 1; s < NUM_STAGES; s++)
      ent_rd[s] <= ent_rd[s-1];
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for pipe_hazard_ctrl (NUM_STAGES=3).
// Expectations follow PIPE_FORWARD_EN; a 4-bit-counter twin instance exercises saturation.
module tb_pipe_hazard_ctrl;

  localparam int NS = 3;

  logic          clk;
  logic          reset;
  logic          id_valid;
  logic [4:0]    id_rn;
  logic [4:0]    id_rm;
  logic          id_uses_rn;
  logic          id_uses_rm;
  logic [4:0]    id_rd;
  logic          id_reg_write;
  logic          id_mem_read;
  logic          br_taken;
  logic          stall;
  logic          flush;
  logic [1:0]    fwd_a;
  logic [1:0]    fwd_b;
  logic [NS-1:0] stage_valid;
  logic [15:0]   stall_cnt;
  logic          sat_stall;
  logic          sat_flush;
  logic [1:0]    sat_fwd_a;
  logic [1:0]    sat_fwd_b;
  logic [NS-1:0] sat_stage_valid;
  logic [3:0]    sat_stall_cnt;

  pipe_hazard_ctrl #(.NUM_STAGES(NS), .REG_AW(5), .ZERO_REG(31), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .br_taken(br_taken),
    .stall(stall), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stage_valid(stage_valid), .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.NUM_STAGES(NS), .REG_AW(5), .ZERO_REG(31), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .br_taken(br_taken),
    .stall(sat_stall), .flush(sat_flush), .fwd_a(sat_fwd_a), .fwd_b(sat_fwd_b),
    .stage_valid(sat_stage_valid), .stall_cnt(sat_stall_cnt)
  );

  typedef struct packed {
    logic       v;
    logic [4:0] rn;
    logic [4:0] rm;
    logic       urn;
    logic       urm;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       br;
  } instr_t;

  typedef struct packed {
    logic        stall;
    logic        flush;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [2:0]  sv;
    logic [15:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    passes = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic instr_t alu(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm);
    instr_t x;
    x = '0;
    x.v = 1'b1; x.rn = rn; x.rm = rm; x.urn = 1'b1; x.urm = 1'b1; x.rd = rd; x.rw = 1'b1;
    return x;
  endfunction

  function automatic instr_t ld(input logic [4:0] rd, input logic [4:0] rn);
    instr_t x;
    x = '0;
    x.v = 1'b1; x.rn = rn; x.urn = 1'b1; x.rd = rd; x.rw = 1'b1; x.mr = 1'b1;
    return x;
  endfunction

  function automatic instr_t bl_instr();
    instr_t x;
    x = '0;
    x.v = 1'b1; x.rd = 5'd30; x.rw = 1'b1;
    return x;
  endfunction

  function automatic instr_t nop();
    instr_t x;
    x = '0;
    return x;
  endfunction

  function automatic instr_t with_br(input instr_t i);
    instr_t x;
    x = i;
    x.br = 1'b1;
    return x;
  endfunction

  function automatic exp_t ex(input logic s, input logic f, input logic [1:0] a, input logic [1:0] b,
                              input logic [2:0] sv, input logic [15:0] c);
    exp_t e;
    e.stall = s; e.flush = f; e.fa = a; e.fb = b; e.sv = sv; e.cnt = c;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
  endtask

  task automatic driveInputs(input instr_t ins);
    id_valid     = ins.v;
    id_rn        = ins.rn;
    id_rm        = ins.rm;
    id_uses_rn   = ins.urn;
    id_uses_rm   = ins.urm;
    id_rd        = ins.rd;
    id_reg_write = ins.rw;
    id_mem_read  = ins.mr;
    br_taken     = ins.br;
  endtask

  task automatic applyStimulus(input string tag, input instr_t ins, input exp_t e);
    exp_t        w;
    string       t;
    logic [15:0] sat_want;
    driveInputs(ins);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    w = exp_q.pop_front();
    t = tag_q.pop_front();
    sat_want = (w.cnt > 16'd15) ? 16'd15 : w.cnt;
    checkOutput({t, ".stall"}, 32'(stall), 32'(w.stall));
    checkOutput({t, ".flush"}, 32'(flush), 32'(w.flush));
    checkOutput({t, ".fwd_a"}, 32'(fwd_a), 32'(w.fa));
    checkOutput({t, ".fwd_b"}, 32'(fwd_b), 32'(w.fb));
    checkOutput({t, ".stage_valid"}, 32'(stage_valid), 32'(w.sv));
    checkOutput({t, ".stall_cnt"}, 32'(stall_cnt), 32'(w.cnt));
    checkOutput({t, ".sat_cnt"}, 32'(sat_stall_cnt), 32'(sat_want));
    checkOutput({t, ".sat_outs"},
                32'({sat_stall, sat_flush, sat_fwd_a, sat_fwd_b, sat_stage_valid}),
                32'({w.stall, w.flush, w.fa, w.fb, w.sv}));
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input string tag, input instr_t ins);
    reset = 1'b1;
    driveInputs(ins);
    @(posedge clk);
    #1;
    applyStimulus(tag, ins, ex(0, 0, 2'b00, 2'b00, 3'b000, 16'd0));
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] ecnt;
    instr_t      gate;

    // Reset with a live reader in ID, then the first cycle out of reset
    doReset("rst", alu(5'd3, 5'd3, 5'd3));
    applyStimulus("rst.after", alu(5'd3, 5'd3, 5'd3), ex(0, 0, 2'b00, 2'b00, 3'b000, 16'd0));

`ifndef PIPE_FORWARD_EN
    doReset("raw.rst", nop());
    applyStimulus("raw.add",  alu(5'd1, 5'd2, 5'd3), ex(0, 0, 2'b00, 2'b00, 3'b000, 16'd0));
    applyStimulus("raw.sub1", alu(5'd2, 5'd1, 5'd4), ex(1, 0, 2'b00, 2'b00, 3'b001, 16'd0));
    applyStimulus("raw.sub2", alu(5'd2, 5'd1, 5'd4), ex(1, 0, 2'b00, 2'b00, 3'b010, 16'd1));
    applyStimulus("raw.sub3", alu(5'd2, 5'd1, 5'd4), ex(0, 0, 2'b00, 2'b00, 3'b100, 16'd2));
    applyStimulus("raw.idle", nop(),                 ex(0, 0, 2'b00, 2'b00, 3'b001, 16'd2));

    doReset("mid.rst0", nop());
    applyStimulus("mid.wr",    alu(5'd1, 5'd2, 5'd3), ex(0, 0, 2'b00, 2'b00, 3'b000, 16'd0));
    applyStimulus("mid.stall", alu(5'd2, 5'd1, 5'd4), ex(1, 0, 2'b00, 2'b00, 3'b001, 16'd0));
    doReset("mid.rst", alu(5'd2, 5'd1, 5'd4));
`else
    doReset("fw.rst", nop());
    applyStimulus("fw.add",   alu(5'd1, 5'd2, 5'd3),  ex(0, 0, 2'b00, 2'b00, 3'b000, 16'd0));
    applyStimulus("fw.orr",   alu(5'd4, 5'd1, 5'd5),  ex(0, 0, 2'b01, 2'b00, 3'b001, 16'd0));
    applyStimulus("fw.gap",   alu(5'd6, 5'd1, 5'd4),  ex(0, 0, 2'b10, 2'b01, 3'b011, 16'd0));
    applyStimulus("fw.dup",   alu(5'd6, 5'd6, 5'd2),  ex(0, 0, 2'b01, 2'b00, 3'b111, 16'd0));
    applyStimulus("fw.young", alu(5'd10, 5'd6, 5'd6), ex(0, 0, 2'b01, 2'b01, 3'b111, 16'd0));

    doReset("lu.rst", nop());
    applyStimulus("lu.ld",   ld(5'd5, 5'd2),        ex(0, 0, 2'b00, 2'b00, 3'b000, 16'd0));
    applyStimulus("lu.use1", alu(5'd6, 5'd5, 5'd5), ex(1, 0, 2'b01, 2'b01, 3'b001, 16'd0));
    applyStimulus("lu.use2", alu(5'd6, 5'd5, 5'd5), ex(0, 0, 2'b10, 2'b10, 3'b010, 16'd1));
    applyStimulus("lu.tail", nop(),                 ex(0, 0, 2'b00, 2'b00, 3'b101, 16'd1));

    doReset("mid.rst0", nop());
    applyStimulus("mid.wr",    ld(5'd1, 5'd2),        ex(0, 0, 2'b00, 2'b00, 3'b000, 16'd0));
    applyStimulus("mid.stall", alu(5'd2, 5'd1, 5'd4), ex(1, 0, 2'b01, 2'b00, 3'b001, 16'd0));
    doReset("mid.rst", alu(5'd2, 5'd1, 5'd4));
`endif

    // Second source port and its uses gate
    doReset("rm.rst", nop());
    gate = alu(5'd12, 5'd2, 5'd7);
    gate.urm = 1'b0;
    applyStimulus("rm.wr",   alu(5'd7, 5'd2, 5'd3), ex(0, 0, 2'b00, 2'b00, 3'b000, 16'd0));
    applyStimulus("rm.gate", gate,                  ex(0, 0, 2'b00, 2'b00, 3'b001, 16'd0));
`ifndef PIPE_FORWARD_EN
    applyStimulus("rm.hit",  alu(5'd9, 5'd8, 5'd7), ex(1, 0, 2'b00, 2'b00, 3'b011, 16'd0));
    applyStimulus("rm.wb",   alu(5'd9, 5'd8, 5'd7), ex(0, 0, 2'b00, 2'b00, 3'b110, 16'd1));
`else
    applyStimulus("rm.hit",  alu(5'd9, 5'd8, 5'd7), ex(0, 0, 2'b00, 2'b10, 3'b011, 16'd0));
`endif

    // Zero register never hazards; X30 from BL does
    doReset("z.rst", nop());
    applyStimulus("z.wr", alu(5'd31, 5'd2, 5'd3),   ex(0, 0, 2'b00, 2'b00, 3'b000, 16'd0));
    applyStimulus("z.rd", alu(5'd7, 5'd31, 5'd31), ex(0, 0, 2'b00, 2'b00, 3'b001, 16'd0));
    doReset("bl.rst", nop());
    applyStimulus("bl.bl", bl_instr(), ex(0, 0, 2'b00, 2'b00, 3'b000, 16'd0));
`ifndef PIPE_FORWARD_EN
    applyStimulus("bl.use", alu(5'd8, 5'd30, 5'd9), ex(1, 0, 2'b00, 2'b00, 3'b001, 16'd0));
    gate = alu(5'd8, 5'd30, 5'd9);
    gate.v = 1'b0;
    applyStimulus("bl.inv", gate, ex(0, 0, 2'b00, 2'b00, 3'b010, 16'd1));
`else
    applyStimulus("bl.use", alu(5'd8, 5'd30, 5'd9), ex(0, 0, 2'b01, 2'b00, 3'b001, 16'd0));
`endif

    // Taken branch overrides a pending hazard
    doReset("br.rst", nop());
    applyStimulus("br.ld", ld(5'd5, 5'd2), ex(0, 0, 2'b00, 2'b00, 3'b000, 16'd0));
`ifndef PIPE_FORWARD_EN
    applyStimulus("br.hz", with_br(alu(5'd6, 5'd5, 5'd5)), ex(0, 1, 2'b00, 2'b00, 3'b001, 16'd0));
`else
    applyStimulus("br.hz", with_br(alu(5'd6, 5'd5, 5'd5)), ex(0, 1, 2'b01, 2'b01, 3'b001, 16'd0));
`endif
    applyStimulus("br.nop",   with_br(nop()), ex(0, 1, 2'b00, 2'b00, 3'b010, 16'd0));
    applyStimulus("br.after", nop(),          ex(0, 0, 2'b00, 2'b00, 3'b100, 16'd0));

    // Repeated self-dependent writers drive the counters past the 4-bit ceiling
    doReset("sat.rst", nop());
    ecnt = 16'd0;
`ifndef PIPE_FORWARD_EN
    for (int it = 0; it < 10; it++) begin
      applyStimulus("sat.issue", alu(5'd1, 5'd1, 5'd1),
                    ex(0, 0, 2'b00, 2'b00, (it == 0) ? 3'b000 : 3'b100, ecnt));
      applyStimulus("sat.st1", alu(5'd1, 5'd1, 5'd1), ex(1, 0, 2'b00, 2'b00, 3'b001, ecnt));
      ecnt = ecnt + 16'd1;
      applyStimulus("sat.st2", alu(5'd1, 5'd1, 5'd1), ex(1, 0, 2'b00, 2'b00, 3'b010, ecnt));
      ecnt = ecnt + 16'd1;
    end
    applyStimulus("sat.end", nop(), ex(0, 0, 2'b00, 2'b00, 3'b100, ecnt));
`else
    for (int it = 0; it < 20; it++) begin
      applyStimulus("sat.issue", ld(5'd1, 5'd1),
                    ex(0, 0, (it == 0) ? 2'b00 : 2'b10, 2'b00, (it == 0) ? 3'b000 : 3'b010, ecnt));
      applyStimulus("sat.st", ld(5'd1, 5'd1),
                    ex(1, 0, 2'b01, 2'b00, (it == 0) ? 3'b001 : 3'b101, ecnt));
      ecnt = ecnt + 16'd1;
    end
    applyStimulus("sat.end", nop(), ex(0, 0, 2'b00, 2'b00, 3'b010, ecnt));
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
